imem_responder: RTL and testbench

- Instruction-memory responder serving fetch requests from the fetch stage.
- Presents a request/accept/response handshake with a fixed, configurable number of wait states.
- Word-organised RAM with a separate load port, used by the bench or a boot loader to fill program memory.
- Flags misaligned and out-of-range fetches and returns a NOP for them.

---
 rtl/imem_responder.sv | 110 +++++++++++
 tb/tb_imem_responder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// imem_responder: instruction-memory fetch responder with fixed wait states and a word-wide load port.
// Define IMEM_FETCH_CNT_EN to build the FetchCnt response counter; otherwise FetchCnt reads 32'h0.
module imem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              Req,
  input  logic [31:0]       Addr,
  output logic              Ready,
  output logic              Rvalid,
  output logic [31:0]       Inst,
  output logic              Fault,
  input  logic              We,
  input  logic [ADDR_W-1:0] WAddr,
  input  logic [31:0]       WData,
  output logic [31:0]       FetchCnt,
  output logic [1:0]        dbg_state
);

  // Handshake: a request is accepted on a rising edge where Req & Ready; the response is a
  // one-cycle Rvalid pulse with Inst/Fault valid, no back-pressure, and no request queueing.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  wcnt;
  logic [31:0] addr_q;
  logic [31:0] mem [0:(1 << ADDR_W) - 1];
  logic        accept;
  logic        enter_resp;
  logic [31:0] fetch_addr;
  logic        fetch_fault;

  assign accept     = Req & Ready;
  assign enter_resp = !Clr && (state_nxt == S_RESP);

  always_ff @(posedge Clk) begin
    if (Clr) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
      S_WAIT: if (wcnt == 4'd0) state_nxt = S_RESP;
      S_RESP: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    Ready     = (state == S_IDLE);
    Rvalid    = (state == S_RESP);
    dbg_state = state;
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      wcnt   <= 4'd0;
      addr_q <= 32'h0;
    end else if (accept) begin
      wcnt   <= WAIT_LOAD;
      addr_q <= Addr;
    end else if (state == S_WAIT && wcnt != 4'd0) begin
      wcnt <= wcnt - 4'd1;
    end
  end

  // With zero wait states the capture edge is the acceptance edge, so Addr is used directly.
  assign fetch_addr  = (state == S_IDLE) ? Addr : addr_q;
  assign fetch_fault = (|fetch_addr[1:0]) || (|fetch_addr[31:ADDR_W+2]);

  always_ff @(posedge Clk) begin
    if (We) mem[WAddr] <= WData;
  end

  // Reading mem here sees the pre-edge contents, giving read-before-write on a collision.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      Inst  <= 32'h0;
      Fault <= 1'b0;
    end else if (enter_resp) begin
      Fault <= fetch_fault;
      Inst  <= fetch_fault ? 32'h0 : mem[fetch_addr[ADDR_W+1:2]];
    end
  end

`ifdef IMEM_FETCH_CNT_EN
  logic [31:0] fetch_cnt;

  always_ff @(posedge Clk) begin
    if (Clr)         fetch_cnt <= 32'h0;
    else if (Rvalid) fetch_cnt <= fetch_cnt + 32'd1;
  end

  assign FetchCnt = fetch_cnt;
`else
  assign FetchCnt = 32'h0;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: three responders (0, 1 and 3 wait states) sharing reset and load port,
// checked by vector table, corner-case sequences and random fetches against a memory model.
module tb_imem_responder;

  localparam int AW = 10;

  typedef struct {
    int          k;
    logic [31:0] addr;
    logic        cw;
    logic [AW-1:0] cwa;
    logic [31:0] cwd;
    logic [31:0] e_inst;
    logic        e_fault;
  } vec_t;

  logic          clk = 1'b0;
  logic          clr;
  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic [31:0]   addr;
  logic [2:0]    req;
  logic [2:0]    ready;
  logic [2:0]    rvalid;
  logic [2:0]    fault;
  logic [31:0]   inst [3];
  logic [31:0]   fcnt [3];
  logic [1:0]    dbg  [3];

  int ws [3] = '{0, 1, 3};
  int exp_cnt [3];
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] mdl [1024];
  logic [31:0] exp_q [$];
  vec_t tbl [11];

  always #5 clk = ~clk;

  imem_responder #(.ADDR_W(AW), .WAIT_STATES(0)) u_ws0 (
    .Clk(clk), .Clr(clr), .Req(req[0]), .Addr(addr), .Ready(ready[0]), .Rvalid(rvalid[0]),
    .Inst(inst[0]), .Fault(fault[0]), .We(we), .WAddr(waddr), .WData(wdata),
    .FetchCnt(fcnt[0]), .dbg_state(dbg[0]));

  imem_responder #(.ADDR_W(AW), .WAIT_STATES(1)) u_ws1 (
    .Clk(clk), .Clr(clr), .Req(req[1]), .Addr(addr), .Ready(ready[1]), .Rvalid(rvalid[1]),
    .Inst(inst[1]), .Fault(fault[1]), .We(we), .WAddr(waddr), .WData(wdata),
    .FetchCnt(fcnt[1]), .dbg_state(dbg[1]));

  imem_responder #(.ADDR_W(AW), .WAIT_STATES(3)) u_ws3 (
    .Clk(clk), .Clr(clr), .Req(req[2]), .Addr(addr), .Ready(ready[2]), .Rvalid(rvalid[2]),
    .Inst(inst[2]), .Fault(fault[2]), .We(we), .WAddr(waddr), .WData(wdata),
    .FetchCnt(fcnt[2]), .dbg_state(dbg[2]));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %h expected %h", name, k, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_fc(input int k);
`ifdef IMEM_FETCH_CNT_EN
    return 32'(exp_cnt[k]);
`else
    return 32'h0;
`endif
  endfunction

  // Reference: misaligned or beyond the 4 KiB window faults with a NOP, else the stored word.
  function automatic logic [32:0] ref_fetch(input logic [31:0] a);
    if ((a % 32'd4) != 0 || a >= 32'(1 << (AW + 2))) return {1'b1, 32'h0};
    return {1'b0, mdl[int'(a / 32'd4)]};
  endfunction

  task automatic load(input logic [AW-1:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    step();
    we = 1'b0;
    mdl[a] = d;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 3; i++) exp_cnt[i] = 0;
  endtask

  task automatic fetch(input int k, input logic [31:0] a, input logic [31:0] e_inst, input logic e_fault,
                       input logic cw, input logic [AW-1:0] cwa, input logic [31:0] cwd);
    int n;
    addr = a;
    req[k] = 1'b1;
    n = 0;
    while (!ready[k] && n < 20) begin
      step();
      n++;
    end
    if (!ready[k]) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout dut%0d: got ready=0 expected ready=1 within 20 cycles", k);
      req[k] = 1'b0;
      return;
    end
    exp_q.push_back(e_inst);
    if (cw) begin
      we = 1'b1; waddr = cwa; wdata = cwd;
    end
    step();
    req[k] = 1'b0;
    we = 1'b0;
    addr = $urandom();
    if (cw) mdl[cwa] = cwd;
    for (int i = 0; i < ws[k]; i++) begin
      check("wait_rvalid", k, rvalid[k], 0);
      check("wait_ready", k, ready[k], 0);
      step();
    end
    check("rvalid", k, rvalid[k], 1);
    check("ready_resp", k, ready[k], 0);
    check("inst", k, inst[k], exp_q.pop_front());
    check("fault", k, fault[k], e_fault);
    exp_cnt[k]++;
    step();
    check("rvalid_fall", k, rvalid[k], 0);
    check("ready_back", k, ready[k], 1);
    check("inst_hold", k, inst[k], e_inst);
    check("fetch_cnt", k, fcnt[k], exp_fc(k));
  endtask

  task automatic fetch_ref(input int k, input logic [31:0] a);
    logic [32:0] e;
    e = ref_fetch(a);
    fetch(k, a, e[31:0], e[32], 1'b0, '0, 32'h0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] e;
    logic [31:0] a;
    logic        cw;
    logic [AW-1:0] cwa;
    logic [31:0] cwd;
    int k;
    int r;

    tbl[0]  = '{1, 32'h0000_0000, 1'b0, 10'd0, 32'h0,         32'h2001_0005, 1'b0};
    tbl[1]  = '{1, 32'h0000_0004, 1'b0, 10'd0, 32'h0,         32'h0800_0000, 1'b0};
    tbl[2]  = '{1, 32'h0000_0002, 1'b0, 10'd0, 32'h0,         32'h0,         1'b1};
    tbl[3]  = '{1, 32'h0000_1000, 1'b0, 10'd0, 32'h0,         32'h0,         1'b1};
    tbl[4]  = '{1, 32'h0000_0FFC, 1'b0, 10'd0, 32'h0,         32'hDEAD_BEEF, 1'b0};
    tbl[5]  = '{0, 32'h0000_000C, 1'b1, 10'd3, 32'h5555_5555, 32'hAAAA_AAAA, 1'b0};
    tbl[6]  = '{0, 32'h0000_000C, 1'b0, 10'd0, 32'h0,         32'h5555_5555, 1'b0};
    tbl[7]  = '{2, 32'h0000_0004, 1'b0, 10'd0, 32'h0,         32'h0800_0000, 1'b0};
    tbl[8]  = '{2, 32'h8000_0000, 1'b0, 10'd0, 32'h0,         32'h0,         1'b1};
    tbl[9]  = '{1, 32'h0000_000C, 1'b1, 10'd3, 32'h1234_5678, 32'h1234_5678, 1'b0};
    tbl[10] = '{2, 32'h0000_0003, 1'b0, 10'd0, 32'h0,         32'h0,         1'b1};

    clr = 1'b1; we = 1'b0; waddr = '0; wdata = 32'h0; addr = 32'h0; req = 3'b000;
    for (int i = 0; i < 3; i++) exp_cnt[i] = 0;
    step();
    step();
    // Whole memory is filled while reset is held, so every later read also covers writes under Clr.
    for (int i = 0; i < 1024; i++) load(AW'(i), $urandom());
    clr = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      check("rst_ready", i, ready[i], 1);
      check("rst_rvalid", i, rvalid[i], 0);
      check("rst_fault", i, fault[i], 0);
      check("rst_inst", i, inst[i], 32'h0);
      check("rst_fetch_cnt", i, fcnt[i], 32'h0);
      check("rst_dbg_idle", i, dbg[i], 2'd0);
    end

    load(10'd0, 32'h2001_0005);
    load(10'd1, 32'h0800_0000);
    load(10'd3, 32'hAAAA_AAAA);
    load(10'd1023, 32'hDEAD_BEEF);

    for (int i = 0; i < 11; i++)
      fetch(tbl[i].k, tbl[i].addr, tbl[i].e_inst, tbl[i].e_fault, tbl[i].cw, tbl[i].cwa, tbl[i].cwd);

    // Zero wait states with Req held: one response every second cycle, nothing extra.
    addr = 32'h0;
    req[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("zw_ready", 0, ready[0], 32'((i % 2) == 0));
      check("zw_rvalid", 0, rvalid[0], 32'((i % 2) == 1));
      if (i % 2 == 1) check("zw_inst", 0, inst[0], mdl[0]);
      step();
    end
    req[0] = 1'b0;
    exp_cnt[0] += 4;
    check("zw_fetch_cnt", 0, fcnt[0], exp_fc(0));
    step();
    check("zw_quiet", 0, rvalid[0], 0);

    // Clr one cycle after acceptance aborts a 3-wait-state fetch.
    addr = 32'h0;
    req[2] = 1'b1;
    step();
    req[2] = 1'b0;
    check("abort_ready_wait", 2, ready[2], 0);
    pulse_clr();
    check("abort_ready", 2, ready[2], 1);
    for (int i = 0; i < 6; i++) begin
      check("abort_no_rvalid", 2, rvalid[2], 0);
      step();
    end
    check("abort_inst_clr", 2, inst[2], 32'h0);
    fetch(2, 32'h0, 32'h2001_0005, 1'b0, 1'b0, '0, 32'h0);

    // Clr landing in the Rvalid cycle: pulse still seen, counter and Inst cleared.
    fetch_ref(1, 32'h4);
    addr = 32'h4;
    req[1] = 1'b1;
    step();
    req[1] = 1'b0;
    step();
    check("coinc_rvalid", 1, rvalid[1], 1);
    check("coinc_inst", 1, inst[1], 32'h0800_0000);
    pulse_clr();
    check("coinc_rvalid_fall", 1, rvalid[1], 0);
    check("coinc_ready", 1, ready[1], 1);
    check("coinc_fetch_cnt", 1, fcnt[1], 32'h0);
    check("coinc_inst_clr", 1, inst[1], 32'h0);

    // Five fetches on one responder, one faulting.
    fetch_ref(1, 32'h0);
    fetch_ref(1, 32'h4);
    fetch_ref(1, 32'h8);
    fetch_ref(1, 32'h2);
    fetch_ref(1, 32'hFFC);
`ifdef IMEM_FETCH_CNT_EN
    check("cnt_five", 1, fcnt[1], 32'd5);
`else
    check("cnt_tied", 1, fcnt[1], 32'd0);
`endif
    pulse_clr();
    for (int i = 0; i < 3; i++) check("cnt_clr", i, fcnt[i], 32'h0);

    // Random fetches, loads and acceptance-edge collisions against the memory model.
    for (int it = 0; it < 75; it++) begin
      k = it % 3;
      r = $urandom_range(0, 9);
      if (r < 6)      a = 32'($urandom_range(0, 1023)) * 32'd4;
      else if (r < 8) a = (32'($urandom_range(0, 1023)) * 32'd4) | 32'($urandom_range(1, 3));
      else begin
        a = $urandom();
        a[12 + $urandom_range(0, 19)] = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) load(AW'($urandom_range(0, 1023)), $urandom());
      cw  = ($urandom_range(0, 2) == 0);
      cwa = ($urandom_range(0, 1) == 0) ? a[AW+1:2] : AW'($urandom_range(0, 1023));
      cwd = $urandom();
      // A write on the acceptance edge lands before capture only when there are wait states.
      if (cw && ws[k] > 0) mdl[cwa] = cwd;
      e = ref_fetch(a);
      fetch(k, a, e[31:0], e[32], cw, cwa, cwd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
